// File: rtl/prog_loader.sv
// Streaming program loader: parses 0x55 / LEN_HI / LEN_LO / payload / checksum
// frames from the UART byte stream and writes the payload into program memory.
//
// state  | meaning
// IDLE   | waiting for the 0x55 magic byte, CPU free to run
// LEN_HI | magic seen, next byte is the length high byte
// LEN_LO | next byte is the length low byte
// DATA   | payload bytes, one memory write each
// CSUM   | next byte is the checksum
module prog_loader #(
    parameter int addr_width = 8,
    parameter int TIMEOUT    = 12000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [addr_width-1:0] mem_addr,
    output logic [7:0]            mem_din,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4
    } state_t;

    localparam logic [7:0]  MAGIC    = 8'h55;
    localparam logic [31:0] TMR_LOAD = 32'(TIMEOUT);

    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [addr_width-1:0] r_len;
    logic [addr_width-1:0] r_addr;
    logic [7:0]            r_sum;
    logic [31:0]           r_tmr;
    logic [addr_width-1:0] r_mem_addr;
    logic [7:0]            r_mem_din;
    logic                  r_mem_we;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_err;

    logic [15:0]           w_len_full;
    logic [7:0]            w_csum;
    logic                  w_unused_len;

    assign w_len_full   = {r_len_hi, rx_data};
    assign w_csum       = r_sum + rx_data;
    // Length bits above addr_width are deliberately discarded.
    assign w_unused_len = ^w_len_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len_hi   <= 8'h00;
            r_len      <= '0;
            r_addr     <= '0;
            r_sum      <= 8'h00;
            r_tmr      <= 32'd0;
            r_mem_addr <= '0;
            r_mem_din  <= 8'h00;
            r_mem_we   <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (rx_valid) begin
                r_tmr <= TMR_LOAD;
                case (r_state)
                    IDLE: begin
                        if (rx_data == MAGIC) begin
                            r_state    <= LEN_HI;
                            r_done     <= 1'b0;
                            r_err      <= 1'b0;
                            r_sum      <= 8'h00;
                            r_addr     <= '0;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                    LEN_HI: begin
                        r_len_hi <= rx_data;
                        r_state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_len   <= w_len_full[addr_width-1:0];
                        r_state <= DATA;
                    end
                    DATA: begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_din  <= rx_data;
                        r_sum      <= w_csum;
                        r_addr     <= r_addr + 1'b1;
                        if (r_addr == r_len) begin
                            r_state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (w_csum == 8'h00) begin
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_cpu_hold <= 1'b0;
                        r_state    <= IDLE;
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_cpu_hold <= 1'b0;
                    end
                endcase
            end else if (r_state != IDLE) begin
                // Down-counter reloaded on every byte; terminal count aborts the frame.
                if (r_tmr <= 32'd1) begin
                    r_state    <= IDLE;
                    r_err      <= 1'b1;
                    r_cpu_hold <= 1'b0;
                    r_tmr      <= 32'd0;
                end else begin
                    r_tmr <= r_tmr - 32'd1;
                end
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (addr_width = 4, TIMEOUT = 50) with a small
// program-memory model fed from the write port.
module tb_prog_loader;

    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:15];
    int wr_cnt = 0;
    int run    = 0;
    int maxrun = 0;
    logic [7:0] q [$];

    prog_loader #(.addr_width(AW), .TIMEOUT(50)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: samples the write port on the rising edge like the real RAM.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
            wr_cnt        <= wr_cnt + 1;
            run           <= run + 1;
            if (run + 1 > maxrun) maxrun <= run + 1;
        end else begin
            run <= 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_q(input int gap);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic wr_check(input string tag, input logic [7:0] a, input logic [7:0] d);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
        check({tag, "_addr"}, {28'd0, mem_addr}, {24'd0, a});
        check({tag, "_din"}, {24'd0, mem_din}, {24'd0, d});
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, {28'd0, mem_addr}, 32'd0);
        check({tag, "_din"}, {24'd0, mem_din}, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int base;
        int k;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst_n = 1'b1;
        idle(1);

        // Frame with bad checksum 0x97
        base = wr_cnt;
        send_byte(8'h55);
        check("a_hold_rise", {31'd0, cpu_hold}, 32'd1);
        idle(1);
        send_byte(8'h00); idle(1);
        send_byte(8'h02); idle(1);
        check("a_no_we_hdr", {31'd0, mem_we}, 32'd0);
        send_byte(8'h11); wr_check("a_w0", 8'h0, 8'h11);
        idle(1);
        check("a_we_pulse", {31'd0, mem_we}, 32'd0);
        send_byte(8'h22); wr_check("a_w1", 8'h1, 8'h22);
        idle(1);
        send_byte(8'h33); wr_check("a_w2", 8'h2, 8'h33);
        idle(1);
        check("a_hold_mid", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h97);
        check("a_err", {31'd0, err}, 32'd1);
        check("a_done", {31'd0, done}, 32'd0);
        check("a_hold_fall", {31'd0, cpu_hold}, 32'd0);
        check("a_wr_cnt", wr_cnt - base, 32'd3);

        // Same frame, good checksum 0x9A; err must clear on the magic
        idle(2);
        send_byte(8'h55);
        check("b_err_clr", {31'd0, err}, 32'd0);
        q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_q(1);
        send_byte(8'h9A);
        check("b_done", {31'd0, done}, 32'd1);
        check("b_err", {31'd0, err}, 32'd0);
        check("b_hold", {31'd0, cpu_hold}, 32'd0);
        check("b_mem0", {24'd0, mem[0]}, 32'h11);
        check("b_mem1", {24'd0, mem[1]}, 32'h22);
        check("b_mem2", {24'd0, mem[2]}, 32'h33);

        // Noise then minimal frame (L = 0)
        idle(2);
        base = wr_cnt;
        q = '{8'h00, 8'hFF, 8'h12};
        send_q(1);
        check("noise_hold", {31'd0, cpu_hold}, 32'd0);
        check("noise_wr", wr_cnt - base, 32'd0);
        check("noise_done_kept", {31'd0, done}, 32'd1);
        q = '{8'h55, 8'h00, 8'h00, 8'hA5, 8'h5B};
        send_q(1);
        check("noise_done", {31'd0, done}, 32'd1);
        check("noise_mem0", {24'd0, mem[0]}, 32'hA5);
        check("noise_wr2", wr_cnt - base, 32'd1);

        // 0x55 inside a frame is data, not a resync
        q = '{8'h55, 8'h00, 8'h01, 8'h55, 8'h55, 8'h56};
        send_q(1);
        check("nosync_done", {31'd0, done}, 32'd1);
        check("nosync_err", {31'd0, err}, 32'd0);
        check("nosync_mem1", {24'd0, mem[1]}, 32'h55);

        // High length bits ignored: 0x12F1 -> L = 1 with 4-bit addresses
        base = wr_cnt;
        q = '{8'h55, 8'h12, 8'hF1, 8'h01, 8'h02, 8'hFD};
        send_q(1);
        check("lenmask_wr", wr_cnt - base, 32'd2);
        check("lenmask_done", {31'd0, done}, 32'd1);

        // Full-memory wrap: L = 15, payload 0..15, checksum 0x88
        base = wr_cnt;
        q = '{8'h55, 8'h00, 8'h0F};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'h88);
        send_q(1);
        check("wrap_wr", wr_cnt - base, 32'd16);
        check("wrap_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap_mem%0d", i), {24'd0, mem[i]}, i);
        end

        // Timeout after one payload byte
        idle(2);
        base = wr_cnt;
        q = '{8'h55, 8'h00, 8'h05};
        send_q(1);
        send_byte(8'hAA);
        wr_check("to_w0", 8'h0, 8'hAA);
        k = 0;
        while (!err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("to_seen", {31'd0, err}, 32'd1);
        check("to_window", (k >= 49 && k <= 51) ? 32'd1 : 32'd0, 32'd1);
        if (!(k >= 49 && k <= 51)) $display("FAIL to_cycles observed=%0d expected=50", k);
        check("to_hold", {31'd0, cpu_hold}, 32'd0);
        check("to_done", {31'd0, done}, 32'd0);
        check("to_wr", wr_cnt - base, 32'd1);
        check("to_mem0", {24'd0, mem[0]}, 32'hAA);
        q = '{8'h55, 8'h00, 8'h00, 8'hA5, 8'h5B};
        send_q(1);
        check("to_after_done", {31'd0, done}, 32'd1);
        check("to_after_err", {31'd0, err}, 32'd0);

        // Reset in DATA after two writes
        idle(2);
        base = wr_cnt;
        q = '{8'h55, 8'h00, 8'h05, 8'h01, 8'h02};
        send_q(1);
        rst_n = 1'b0;
        send_byte(8'h03);
        reset_check("rst_mid");
        rst_n = 1'b1;
        q = '{8'h04, 8'h05};
        send_q(1);
        idle(1);
        check("rst_wr", wr_cnt - base, 32'd2);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        q = '{8'h55, 8'h00, 8'h00, 8'h3C, 8'hC4};
        send_q(1);
        check("rst_after_done", {31'd0, done}, 32'd1);
        check("rst_after_mem0", {24'd0, mem[0]}, 32'h3C);
        check("single_we_only", maxrun, 32'd1);

        // Back-to-back strobes: whole frame with rx_valid held high
        idle(2);
        base = wr_cnt;
        q = '{8'h55, 8'h00, 8'h07, 8'h10, 8'h21, 8'h32, 8'h43,
              8'h54, 8'h65, 8'h76, 8'h87, 8'hA4};
        send_q(0);
        idle(1);
        check("b2b_wr", wr_cnt - base, 32'd8);
        check("b2b_run", maxrun, 32'd8);
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_err", {31'd0, err}, 32'd0);
        check("b2b_mem0", {24'd0, mem[0]}, 32'h10);
        check("b2b_mem3", {24'd0, mem[3]}, 32'h43);
        check("b2b_mem7", {24'd0, mem[7]}, 32'h87);
        check("b2b_mem8_kept", {24'd0, mem[8]}, 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
